mult_div_sequencer: RTL and testbench

//  Iterative multiply/divide sequencer for the MIPS EX stage. It runs MULT, MULTU, DIV and DIVU over
//  N_BITS cycles using one shared add/sub/shift datapath, and owns the HI/LO registers.

---
 rtl/mult_div_sequencer.sv | 176 +++++++++++++++++
 tb/tb_mult_div_sequencer.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mult_div_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer for the EX stage. It owns HI/LO and performs the MTHI/MTLO writes.
// One shared N+1-bit add/sub does shift-add multiply or restoring divide, one bit per CALC cycle.
//
// state | meaning
// IDLE  | waiting for i_start; MTHI/MTLO commit here
// CALC  | N_BITS iterations of the shared datapath
// FIX   | sign correction; HI/LO written on exit
// DONE  | o_done pulse, result already visible
module mult_div_sequencer #(
  parameter int N_BITS    = 32,
  parameter int N_BITS_OP = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [N_BITS_OP-1:0] i_op,
  input  logic [N_BITS-1:0]    i_dato_A,
  input  logic [N_BITS-1:0]    i_dato_B,
  input  logic                 i_flush,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [N_BITS-1:0]    o_hi,
  output logic [N_BITS-1:0]    o_lo
);

  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic              bzero_q, bzero_d;
  logic [N_BITS-1:0] a_raw_q, a_raw_d;
  logic [N_BITS-1:0] opnd_q, opnd_d;
  logic [N_BITS-1:0] acc_hi_q, acc_hi_d;
  logic [N_BITS-1:0] acc_lo_q, acc_lo_d;
  logic [N_BITS-1:0] hi_q, hi_d;
  logic [N_BITS-1:0] lo_q, lo_d;

  logic              op_signed, sign_a, sign_b;
  logic [N_BITS-1:0] mag_a, mag_b;
  logic [N_BITS:0]   alu_x, alu_y, alu_r;
  logic [2*N_BITS-1:0] prod, prod_fix;

  always_comb begin
    op_signed = ~i_op[0];
    sign_a    = op_signed & i_dato_A[N_BITS-1];
    sign_b    = op_signed & i_dato_B[N_BITS-1];
    mag_a     = sign_a ? -i_dato_A : i_dato_A;
    mag_b     = sign_b ? -i_dato_B : i_dato_B;

    // Divide trial-subtracts the shifted partial remainder; multiply adds the multiplicand to HI.
    alu_x = is_div_q ? {acc_hi_q, acc_lo_q[N_BITS-1]} : {1'b0, acc_hi_q};
    alu_y = {1'b0, opnd_q};
    alu_r = is_div_q ? (alu_x - alu_y) : (alu_x + alu_y);

    prod     = {acc_hi_q, acc_lo_q};
    prod_fix = neg_res_q ? -prod : prod;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    bzero_d   = bzero_q;
    a_raw_d   = a_raw_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (i_start && !i_flush) begin
          if (!i_op[2]) begin
            state_d   = S_CALC;
            cnt_d     = '0;
            is_div_d  = i_op[1];
            neg_res_d = sign_a ^ sign_b;
            neg_rem_d = sign_a;
            bzero_d   = (i_dato_B == '0);
            a_raw_d   = i_dato_A;
            acc_hi_d  = '0;
            opnd_d    = i_op[1] ? mag_b : mag_a;
            acc_lo_d  = i_op[1] ? mag_a : mag_b;
          end else if (i_op[1:0] == 2'b00) begin
            hi_d = i_dato_A;
          end else if (i_op[1:0] == 2'b01) begin
            lo_d = i_dato_A;
          end
        end
      end
      S_CALC: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else begin
          if (is_div_q) begin
            if (!alu_r[N_BITS]) begin
              acc_hi_d = alu_r[N_BITS-1:0];
              acc_lo_d = {acc_lo_q[N_BITS-2:0], 1'b1};
            end else begin
              acc_hi_d = alu_x[N_BITS-1:0];
              acc_lo_d = {acc_lo_q[N_BITS-2:0], 1'b0};
            end
          end else if (acc_lo_q[0]) begin
            {acc_hi_d, acc_lo_d} = {alu_r, acc_lo_q[N_BITS-1:1]};
          end else begin
            {acc_hi_d, acc_lo_d} = {1'b0, acc_hi_q, acc_lo_q[N_BITS-1:1]};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(N_BITS - 1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (i_flush) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (bzero_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else begin
            lo_d = neg_res_q ? -acc_lo_q : acc_lo_q;
            hi_d = neg_rem_q ? -acc_hi_q : acc_hi_q;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      bzero_q   <= 1'b0;
      a_raw_q   <= '0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      bzero_q   <= bzero_d;
      a_raw_q   <= a_raw_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign o_busy = (state_q == S_CALC) || (state_q == S_FIX);
  assign o_done = (state_q == S_DONE);
  assign o_hi   = hi_q;
  assign o_lo   = lo_q;

endmodule

// File: tb/tb_mult_div_sequencer.sv
// Directed bench for mult_div_sequencer: queued expected HI/LO popped on each o_done,
// plus inline timing, flush and reset checks.
module tb_mult_div_sequencer;

  localparam int N = 32;

  logic          clk = 1'b0;
  logic          rst_n, start, flush;
  logic [2:0]    op;
  logic [N-1:0]  a, b, hi, lo;
  logic          busy, done;

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  mult_div_sequencer #(.N_BITS(N), .N_BITS_OP(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_op(op),
    .i_dato_A(a), .i_dato_B(b), .i_flush(flush),
    .o_busy(busy), .o_done(done), .o_hi(hi), .o_lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every o_done must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && done === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("hi_lo_result", {hi, lo}, e);
      end
    end
  end

  // Start cycle is 0; busy must cover cycles 1..N+1 and done appear only in N+2.
  task automatic run_op(input logic [2:0] o, input logic [N-1:0] va, input logic [N-1:0] vb,
                        input logic [N-1:0] ehi, input logic [N-1:0] elo);
    int busy_bad, done_cyc, done_cnt;
    busy_bad = 0; done_cyc = -1; done_cnt = 0;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb;
    exp_q.push_back({ehi, elo});
    for (int c = 1; c <= N + 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== (c <= N + 1)) busy_bad++;
      if (done === 1'b1) begin done_cyc = c; done_cnt++; end
    end
    chk("busy_window", 64'(busy_bad), 64'd0);
    chk("done_cycle", {32'(done_cnt), 32'(done_cyc)}, {32'd1, 32'(N + 2)});
  endtask

  task automatic mt(input logic [2:0] o, input logic [N-1:0] va);
    @(negedge clk);
    start = 1'b1; op = o; a = va;
    @(negedge clk);
    start = 1'b0;
    chk("mt_no_busy", {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_state", {hi, lo}, 64'd0);
    chk("reset_flags", {62'd0, busy, done}, 64'd0);
    rst_n = 1'b1;

    run_op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run_op(3'b001, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000);
    run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(3'b011, 32'd100,       32'd7,         32'd2,         32'd14);
    run_op(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op(3'b011, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234, 32'hFFFF_FFFF);
    run_op(3'b010, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
    run_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    mt(3'b100, 32'h0000_0055);
    chk("mthi", {32'd0, hi}, {32'd0, 32'h55});
    mt(3'b101, 32'h0000_00AA);
    chk("mtlo", {hi, lo}, {32'h55, 32'hAA});
    mt(3'b110, 32'h0000_0123);
    chk("noop_ignored", {hi, lo}, {32'h55, 32'hAA});

    // Start together with flush in IDLE is dropped, MTHI included.
    @(negedge clk);
    start = 1'b1; op = 3'b100; a = 32'hDEAD; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("idle_flush_mthi", {hi, lo}, {32'h55, 32'hAA});

    // MULT flushed in cycle 10; a second start in cycle 5 must not queue.
    begin
      int dn;
      dn = 0;
      @(negedge clk);
      start = 1'b1; op = 3'b000; a = 32'd3; b = 32'd5;
      for (int c = 1; c <= 45; c++) begin
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        if (c == 1)  chk("flush_busy_c1", {63'd0, busy}, 64'd1);
        if (c == 11) chk("flush_idle_c11", {62'd0, busy, done}, 64'd0);
        if (done === 1'b1) dn++;
        if (c == 5) begin start = 1'b1; op = 3'b011; a = 32'd9; b = 32'd2; end
        if (c == 10) flush = 1'b1;
      end
      chk("flush_no_done", 64'(dn), 64'd0);
      chk("flush_keeps_hilo", {hi, lo}, {32'h55, 32'hAA});
    end

    // Reset in cycle 20 of a DIV.
    @(negedge clk);
    start = 1'b1; op = 3'b010; a = 32'hFFFF_FFF9; b = 32'd2;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (c == 20) rst_n = 1'b0;
      if (c == 21) begin
        chk("rst_mid_flags", {62'd0, busy, done}, 64'd0);
        chk("rst_mid_hilo", {hi, lo}, 64'd0);
      end
    end
    rst_n = 1'b1;
    run_op(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
